// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests, turns EXE redirects into flushes plus a
// registered PC redirect, and marks stale fetch responses. Optional counters: PIPE_PERF_EN.
module pipe_ctrl #(
    parameter int unsigned XLEN            = 64,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned CNT_W           = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_stall_req,
    input  logic            id_stall_req,
    input  logic            ex_stall_req,
    input  logic            mem_stall_req,
    input  logic            ex_redirect_valid,
    input  logic [XLEN-1:0] ex_redirect_pc,
    input  logic            fetch_req_fire,
    input  logic            fetch_rsp_fire,
    output logic [4:0]      stall_ctrl,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            fetch_discard,
    output logic            fetch_req_allow,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
);

    localparam logic [CNT_W-1:0] MaxOut = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  disc_cnt_q, disc_cnt_d;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic              accept;

    // A held EXE keeps its redirect asserted, so deferring under a MEM stall loses nothing.
    assign accept = ex_redirect_valid & ~mem_stall_req;

    assign if_id_flush     = accept;
    assign id_ex_flush     = accept;
    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign fetch_req_allow = (out_cnt_q < MaxOut) | fetch_rsp_fire;

    always_comb begin
        stall_ctrl = 5'b00000;
        if (mem_stall_req) begin
            stall_ctrl = 5'b11111;
        end else if (ex_stall_req) begin
            stall_ctrl = 5'b01111;
        end else if (id_stall_req) begin
            stall_ctrl = 5'b00111;
        end else if (if_stall_req || state_q == StDrain) begin
            stall_ctrl = 5'b00011;
        end
    end

    // Illegal events saturate instead of wrapping.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (fetch_req_fire && !fetch_rsp_fire && out_cnt_q < MaxOut) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (fetch_rsp_fire && !fetch_req_fire && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        disc_cnt_d    = disc_cnt_q;
        fetch_discard = 1'b0;
        unique case (state_q)
            StRun: begin
            end
            StDrain: begin
                fetch_discard = (disc_cnt_q != '0);
                if (fetch_rsp_fire && disc_cnt_q != '0) begin
                    disc_cnt_d = disc_cnt_q - CNT_W'(1);
                    if (disc_cnt_q == CNT_W'(1)) begin
                        state_d = StRun;
                    end
                end else if (disc_cnt_q == '0) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Every fetch still in flight after this cycle belongs to the old path.
        if (accept) begin
            disc_cnt_d = out_cnt_d;
            state_d    = (out_cnt_d != '0) ? StDrain : StRun;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StRun;
            out_cnt_q        <= '0;
            disc_cnt_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            out_cnt_q        <= out_cnt_d;
            disc_cnt_q       <= disc_cnt_d;
            redirect_valid_q <= accept;
            if (accept) begin
                redirect_pc_q <= ex_redirect_pc;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stall_ctrl != 5'b00000) begin
                perf_stall_q <= perf_stall_q + 32'h1;
            end
            if (accept) begin
                perf_flush_q <= perf_flush_q + 32'h1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_flush_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// queue-based model of in-flight fetches.
module tb_pipe_ctrl;

    localparam int MAX = 2;

    logic        clk, rst;
    logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
    logic        ex_redirect_valid;
    logic [63:0] ex_redirect_pc;
    logic        fetch_req_fire, fetch_rsp_fire;
    logic [4:0]  stall_ctrl;
    logic        if_id_flush, id_ex_flush, redirect_valid, fetch_discard, fetch_req_allow;
    logic [63:0] redirect_pc;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.XLEN(64), .MAX_OUTSTANDING(MAX), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
        .ex_stall_req(ex_stall_req), .mem_stall_req(mem_stall_req),
        .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
        .fetch_req_fire(fetch_req_fire), .fetch_rsp_fire(fetch_rsp_fire),
        .stall_ctrl(stall_ctrl), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_discard(fetch_discard), .fetch_req_allow(fetch_req_allow),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        if_stall_req = 0; id_stall_req = 0; ex_stall_req = 0; mem_stall_req = 0;
        ex_redirect_valid = 0; ex_redirect_pc = '0; fetch_req_fire = 0; fetch_rsp_fire = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        cyc();
    endtask

    task automatic test_reset();
        clr_inputs();
        rst = 0;
        #12;
        checks++; if (stall_ctrl !== 5'b0) begin errors++; $display("FAIL reset_stall got %b exp 00000", stall_ctrl); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", redirect_valid); end
        checks++; if (redirect_pc !== 64'h0) begin errors++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
        checks++; if (fetch_discard !== 1'b0) begin errors++; $display("FAIL reset_discard got %b exp 0", fetch_discard); end
        checks++; if (fetch_req_allow !== 1'b1) begin errors++; $display("FAIL reset_allow got %b exp 1", fetch_req_allow); end
        checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL reset_flush got %b exp 00", {if_id_flush, id_ex_flush}); end
        checks++; if ({perf_stall_cnt, perf_flush_cnt} !== 64'h0) begin errors++; $display("FAIL reset_perf got %h exp 0", {perf_stall_cnt, perf_flush_cnt}); end
        @(negedge clk);
        rst = 1;
        cyc();
    endtask

    task automatic test_stall_priority();
        logic [3:0] pat [5];
        logic [4:0] exp [5];
        // {if, id, ex, mem}
        pat[0] = 4'b0110; exp[0] = 5'b01111;
        pat[1] = 4'b0111; exp[1] = 5'b11111;
        pat[2] = 4'b1000; exp[2] = 5'b00011;
        pat[3] = 4'b1100; exp[3] = 5'b00111;
        pat[4] = 4'b0000; exp[4] = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            {if_stall_req, id_stall_req, ex_stall_req, mem_stall_req} = pat[i];
            #1;
            checks++; if (stall_ctrl !== exp[i]) begin errors++; $display("FAIL stall_prio[%0d] got %b exp %b", i, stall_ctrl, exp[i]); end
        end
        clr_inputs();
        cyc();
    endtask

    task automatic test_redirect_basic();
        fetch_req_fire = 1; cyc(); cyc();
        fetch_req_fire = 0;
        ex_redirect_valid = 1; ex_redirect_pc = 64'h8000_0100;
        #1;
        checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL rb_flush got %b exp 11", {if_id_flush, id_ex_flush}); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rb_rv_early got %b exp 0", redirect_valid); end
        cyc();
        ex_redirect_valid = 0; ex_redirect_pc = '0;
        #1;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL rb_rv got %b exp 1", redirect_valid); end
        checks++; if (redirect_pc !== 64'h8000_0100) begin errors++; $display("FAIL rb_rpc got %h exp 8000_0100", redirect_pc); end
        checks++; if (stall_ctrl !== 5'b00011) begin errors++; $display("FAIL rb_drain_stall got %b exp 00011", stall_ctrl); end
        checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL rb_flush_off got %b exp 00", {if_id_flush, id_ex_flush}); end
        cyc();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rb_rv_pulse got %b exp 0", redirect_valid); end
        fetch_rsp_fire = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fetch_discard !== 1'b1) begin errors++; $display("FAIL rb_discard[%0d] got %b exp 1", i, fetch_discard); end
            cyc();
        end
        fetch_rsp_fire = 0;
        #1;
        checks++; if (stall_ctrl !== 5'b00000) begin errors++; $display("FAIL rb_run_stall got %b exp 00000", stall_ctrl); end
        fetch_req_fire = 1; cyc(); fetch_req_fire = 0;
        fetch_rsp_fire = 1;
        #1;
        checks++; if (fetch_discard !== 1'b0) begin errors++; $display("FAIL rb_third_rsp got %b exp 0", fetch_discard); end
        cyc();
        clr_inputs();
    endtask

    task automatic test_redirect_mem_stall();
        ex_redirect_valid = 1; ex_redirect_pc = 64'h0000_0000_1234_5678; mem_stall_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({if_id_flush, id_ex_flush} !== 2'b00) begin errors++; $display("FAIL ms_flush[%0d] got %b exp 00", i, {if_id_flush, id_ex_flush}); end
            checks++; if (stall_ctrl !== 5'b11111) begin errors++; $display("FAIL ms_stall[%0d] got %b exp 11111", i, stall_ctrl); end
            cyc();
            checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ms_rv[%0d] got %b exp 0", i, redirect_valid); end
        end
        mem_stall_req = 0;
        #1;
        checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin errors++; $display("FAIL ms_accept got %b exp 11", {if_id_flush, id_ex_flush}); end
        cyc();
        ex_redirect_valid = 0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h1234_5678) begin errors++; $display("FAIL ms_redirect got %b/%h exp 1/12345678", redirect_valid, redirect_pc); end
        cyc();
        clr_inputs();
    endtask

    task automatic test_drain_reload();
        fetch_req_fire = 1; cyc(); cyc(); fetch_req_fire = 0;
        ex_redirect_valid = 1; ex_redirect_pc = 64'hA; cyc(); ex_redirect_valid = 0;
        fetch_rsp_fire = 1;
        #1;
        checks++; if (fetch_discard !== 1'b1) begin errors++; $display("FAIL dr_first got %b exp 1", fetch_discard); end
        cyc();
        fetch_rsp_fire = 0; fetch_req_fire = 1; cyc(); fetch_req_fire = 0;
        ex_redirect_valid = 1; ex_redirect_pc = 64'hB; cyc(); ex_redirect_valid = 0;
        checks++; if (redirect_pc !== 64'hB) begin errors++; $display("FAIL dr_rpc got %h exp b", redirect_pc); end
        fetch_rsp_fire = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (fetch_discard !== 1'b1) begin errors++; $display("FAIL dr_reload[%0d] got %b exp 1", i, fetch_discard); end
            cyc();
        end
        fetch_rsp_fire = 0;
        #1;
        checks++; if (stall_ctrl !== 5'b00000 || fetch_discard !== 1'b0) begin errors++; $display("FAIL dr_run got %b/%b exp 00000/0", stall_ctrl, fetch_discard); end
        clr_inputs();
    endtask

    task automatic test_back_to_back();
        ex_redirect_valid = 1; ex_redirect_pc = 64'h100; cyc();
        ex_redirect_pc = 64'h200;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h100) begin errors++; $display("FAIL b2b_first got %b/%h exp 1/100", redirect_valid, redirect_pc); end
        cyc();
        ex_redirect_valid = 0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h200) begin errors++; $display("FAIL b2b_second got %b/%h exp 1/200", redirect_valid, redirect_pc); end
        cyc();
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 64'h200) begin errors++; $display("FAIL b2b_end got %b/%h exp 0/200", redirect_valid, redirect_pc); end
        clr_inputs();
    endtask

    task automatic test_limit_reset();
        fetch_req_fire = 1; cyc(); cyc(); fetch_req_fire = 0;
        #1;
        checks++; if (fetch_req_allow !== 1'b0) begin errors++; $display("FAIL lim_full got %b exp 0", fetch_req_allow); end
        fetch_rsp_fire = 1;
        #1;
        checks++; if (fetch_req_allow !== 1'b1) begin errors++; $display("FAIL lim_rsp got %b exp 1", fetch_req_allow); end
        fetch_rsp_fire = 0;
        ex_redirect_valid = 1; ex_redirect_pc = 64'h77; cyc(); ex_redirect_valid = 0;
        #1;
        checks++; if (stall_ctrl !== 5'b00011 || redirect_valid !== 1'b1) begin errors++; $display("FAIL lim_drain got %b/%b exp 00011/1", stall_ctrl, redirect_valid); end
        rst = 0;
        #1;
        checks++; if (stall_ctrl !== 5'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_mid got %b/%b exp 00000/0", stall_ctrl, redirect_valid); end
        fetch_rsp_fire = 1;
        #1;
        checks++; if (fetch_discard !== 1'b0) begin errors++; $display("FAIL rst_discard got %b exp 0", fetch_discard); end
        fetch_rsp_fire = 0;
        @(negedge clk);
        rst = 1;
        cyc();
        checks++; if (redirect_valid !== 1'b0 || fetch_req_allow !== 1'b1) begin errors++; $display("FAIL rst_after got %b/%b exp 0/1", redirect_valid, fetch_req_allow); end
    endtask

    // Model: queue of in-flight fetches, each tagged stale once a redirect overtakes it.
    task automatic test_random();
        bit          stale_q[$];
        logic        exp_rv;
        logic [63:0] exp_rpc;
        int unsigned m_stall, m_flush;
        logic        drain, acc;
        logic [4:0]  e_stall;
        logic [31:0] e_ps, e_pf;
        do_reset();
        exp_rv = 0; exp_rpc = '0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 600; n++) begin
            if_stall_req      = ($urandom_range(0, 3) == 0);
            id_stall_req      = ($urandom_range(0, 4) == 0);
            ex_stall_req      = ($urandom_range(0, 5) == 0);
            mem_stall_req     = ($urandom_range(0, 3) == 0);
            ex_redirect_valid = ($urandom_range(0, 4) == 0);
            ex_redirect_pc    = {$urandom, $urandom};
            fetch_rsp_fire    = (stale_q.size() > 0) && ($urandom_range(0, 1) == 1);
            fetch_req_fire    = (stale_q.size() < MAX || fetch_rsp_fire) && ($urandom_range(0, 1) == 1);
            #1;
            drain = 0;
            foreach (stale_q[k]) if (stale_q[k]) drain = 1;
            e_stall = mem_stall_req ? 5'b11111 : ex_stall_req ? 5'b01111 :
                      id_stall_req ? 5'b00111 : (if_stall_req || drain) ? 5'b00011 : 5'b00000;
            acc = ex_redirect_valid && !mem_stall_req;
            checks++; if (stall_ctrl !== e_stall) begin errors++; $display("FAIL rnd_stall @%0d got %b exp %b", n, stall_ctrl, e_stall); end
            checks++; if (if_id_flush !== acc || id_ex_flush !== acc) begin errors++; $display("FAIL rnd_flush @%0d got %b%b exp %b", n, if_id_flush, id_ex_flush, acc); end
            checks++; if (fetch_discard !== (stale_q.size() > 0 && stale_q[0])) begin errors++; $display("FAIL rnd_discard @%0d got %b", n, fetch_discard); end
            checks++; if (fetch_req_allow !== (stale_q.size() < MAX || fetch_rsp_fire)) begin errors++; $display("FAIL rnd_allow @%0d got %b qsize %0d", n, fetch_req_allow, stale_q.size()); end
            checks++; if (redirect_valid !== exp_rv) begin errors++; $display("FAIL rnd_rv @%0d got %b exp %b", n, redirect_valid, exp_rv); end
            checks++; if (redirect_pc !== exp_rpc) begin errors++; $display("FAIL rnd_rpc @%0d got %h exp %h", n, redirect_pc, exp_rpc); end
            if (fetch_rsp_fire) void'(stale_q.pop_front());
            if (fetch_req_fire) stale_q.push_back(1'b0);
            if (acc) foreach (stale_q[k]) stale_q[k] = 1'b1;
            exp_rv = acc;
            if (acc) exp_rpc = ex_redirect_pc;
            if (e_stall != 5'b0) m_stall++;
            if (acc) m_flush++;
            cyc();
        end
`ifdef PIPE_PERF_EN
        e_ps = m_stall; e_pf = m_flush;
`else
        e_ps = 32'h0; e_pf = 32'h0;
`endif
        checks++; if (perf_stall_cnt !== e_ps) begin errors++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_cnt, e_ps); end
        checks++; if (perf_flush_cnt !== e_pf) begin errors++; $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, e_pf); end
        clr_inputs();
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_redirect_basic();
        test_redirect_mem_stall();
        test_drain_reload();
        test_back_to_back();
        test_limit_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
